// File: rtl/xcache_param_pkg.sv
// Shared xcache configuration definitions: command codes, table geometry and FSM states.
// The readback option in xcache_cfg_decoder is enabled with XCACHE_CFG_READBACK_EN.
package xcache_param_pkg;

  localparam int unsigned MAX_PARTITION = 4;
  localparam int unsigned PART_IDX_W    = $clog2(MAX_PARTITION + 1);
  localparam int unsigned XMEM_AW       = 29;
  localparam int unsigned XMEM_DW       = 32;
  localparam int unsigned CMD_W         = 6;
  localparam int unsigned CMD_MAX_CODE  = 40;

  typedef enum logic [CMD_W-1:0] {
    CMD_SET_SBANK    = 6'd0,
    CMD_SET_RPORT    = 6'd1,
    CMD_SET_APORT    = 6'd2,
    CMD_SET_PART     = 6'd3,
    CMD_PART_NUM     = 6'd4,
    CMD_RANGE_START  = 6'd5,
    CMD_FWD_FIRST    = 6'd6,
    CMD_FWD_LAST     = 6'd39,
    CMD_AXI_MEM_BASE = 6'd40
  } cmd_t;

  // MAX_PARTITION+1 range starts; entry i+1 bounds partition i
  typedef logic [MAX_PARTITION:0][XMEM_AW-1:0] range_tbl_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } cfg_state_t;

  function automatic logic is_fwd_code(input logic [CMD_W-1:0] id);
    return (id >= CMD_FWD_FIRST) && (id <= CMD_FWD_LAST);
  endfunction

endpackage

// File: rtl/xcache_part_lookup.sv
// Address-to-partition compare tree over a range table, with a one-cycle output register.
module xcache_part_lookup
  import xcache_param_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  range_tbl_t            tbl_i,
  input  logic [PART_IDX_W:0]   part_num_i,
  input  logic                  valid_i,
  input  logic [XMEM_AW-1:0]    addr_i,
  output logic                  rsp_valid_o,
  output logic                  hit_o,
  output logic [PART_IDX_W-1:0] part_o,
  output logic [XMEM_AW-1:0]    end_o
);

  logic [XMEM_AW-1:0]    lim_d;
  logic [XMEM_AW-1:0]    nxt_d;
  logic [XMEM_AW-1:0]    end_d;
  logic [PART_IDX_W-1:0] part_d;
  logic                  hit_d;

  logic                  rsp_valid_q;
  logic                  hit_q;
  logic [PART_IDX_W-1:0] part_q;
  logic [XMEM_AW-1:0]    end_q;

  always_comb begin
    lim_d  = '0;
    nxt_d  = '0;
    part_d = '0;
    for (int unsigned i = 0; i <= MAX_PARTITION; i++) begin
      if (part_num_i == (PART_IDX_W+1)'(i)) lim_d = tbl_i[i];
    end
    hit_d = (tbl_i[0] <= addr_i) && (addr_i < lim_d);
    // ascending starts: the last qualifying entry is the owning partition
    for (int unsigned i = 0; i < MAX_PARTITION; i++) begin
      if (((PART_IDX_W+1)'(i) < part_num_i) && (tbl_i[i] <= addr_i)) part_d = PART_IDX_W'(i);
    end
    for (int unsigned i = 1; i <= MAX_PARTITION; i++) begin
      if (part_d == PART_IDX_W'(i - 1)) nxt_d = tbl_i[i];
    end
    end_d = nxt_d - XMEM_AW'(1);
    if (!hit_d) begin
      part_d = '0;
      end_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      part_q      <= '0;
      end_q       <= '0;
    end else begin
      rsp_valid_q <= valid_i;
      if (valid_i) begin
        hit_q  <= hit_d;
        part_q <= part_d;
        end_q  <= end_d;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign hit_o       = hit_q;
  assign part_o      = part_q;
  assign end_o       = end_q;

endmodule

// File: rtl/xcache_cfg_decoder.sv
// Config command responder: shadow range table, validated commit, lookup and command forwarding.
// Define XCACHE_CFG_READBACK_EN to add the active-table readback port.
module xcache_cfg_decoder
  import xcache_param_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_commit,
  input  logic [CMD_W-1:0]      cmd_id,
  input  logic [XMEM_DW-1:0]    cmd_data,
  output logic                  fwd_valid,
  output logic [CMD_W-1:0]      fwd_id,
  output logic [XMEM_DW-1:0]    fwd_data,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [7:0]            sbank,
  output logic [7:0]            rport,
  output logic [7:0]            aport,
  output logic [XMEM_DW-1:0]    axi_mem_base,
  output logic [PART_IDX_W:0]   part_num,
  input  logic                  lkp_valid,
  input  logic [XMEM_AW-1:0]    lkp_addr,
  output logic                  lkp_rsp_valid,
  output logic                  lkp_hit,
  output logic [PART_IDX_W-1:0] lkp_part,
  output logic [XMEM_AW-1:0]    lkp_end
`ifdef XCACHE_CFG_READBACK_EN
  ,
  input  logic                  rd_valid,
  input  logic [PART_IDX_W-1:0] rd_idx,
  output logic [XMEM_AW-1:0]    rd_data,
  output logic                  rd_rsp_valid
`endif
);

  cfg_state_t            state_q;
  range_tbl_t            shd_rs_q;
  range_tbl_t            act_rs_q;
  logic [PART_IDX_W:0]   shd_pn_q;
  logic [PART_IDX_W:0]   act_pn_q;
  logic [PART_IDX_W-1:0] cur_part_q;
  logic [PART_IDX_W-1:0] chk_idx_q;
  logic                  fwd_valid_q;
  logic [CMD_W-1:0]      fwd_id_q;
  logic [XMEM_DW-1:0]    fwd_data_q;
  logic                  err_q;
  logic [7:0]            sbank_q;
  logic [7:0]            rport_q;
  logic [7:0]            aport_q;
  logic [XMEM_DW-1:0]    axi_base_q;

  logic                  accept_d;
  logic [PART_IDX_W-1:0] chk_nxt_d;
  logic                  chk_pn_bad_d;
  logic                  chk_ok_d;
  logic                  chk_last_d;

  assign cmd_ready    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept_d     = cmd_valid && cmd_ready;
  assign chk_nxt_d    = chk_idx_q + PART_IDX_W'(1);
  assign chk_pn_bad_d = (shd_pn_q == '0) || (shd_pn_q > (PART_IDX_W+1)'(MAX_PARTITION));
  assign chk_ok_d     = !chk_pn_bad_d && (shd_rs_q[chk_idx_q] < shd_rs_q[chk_nxt_d]);
  assign chk_last_d   = ({1'b0, chk_idx_q} == (shd_pn_q - (PART_IDX_W+1)'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      shd_rs_q    <= '0;
      act_rs_q    <= '0;
      shd_pn_q    <= (PART_IDX_W+1)'(1);
      act_pn_q    <= (PART_IDX_W+1)'(1);
      cur_part_q  <= '0;
      chk_idx_q   <= '0;
      fwd_valid_q <= 1'b0;
      fwd_id_q    <= '0;
      fwd_data_q  <= '0;
      err_q       <= 1'b0;
      sbank_q     <= '0;
      rport_q     <= '0;
      aport_q     <= '0;
      axi_base_q  <= '0;
    end else begin
      fwd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept_d) begin
            if (cmd_commit) begin
              err_q     <= 1'b0;
              chk_idx_q <= '0;
              state_q   <= ST_CHECK;
            end else begin
              state_q <= ST_LOAD;
              if (cmd_id > CMD_W'(CMD_MAX_CODE)) begin
                err_q <= 1'b1;
              end else if (is_fwd_code(cmd_id)) begin
                fwd_valid_q <= 1'b1;
                fwd_id_q    <= cmd_id;
                fwd_data_q  <= cmd_data;
              end else begin
                case (cmd_id)
                  CMD_SET_SBANK:    sbank_q    <= cmd_data[7:0];
                  CMD_SET_RPORT:    rport_q    <= cmd_data[7:0];
                  CMD_SET_APORT:    aport_q    <= cmd_data[7:0];
                  CMD_AXI_MEM_BASE: axi_base_q <= cmd_data;
                  CMD_SET_PART: begin
                    if (cmd_data > XMEM_DW'(MAX_PARTITION)) err_q <= 1'b1;
                    else cur_part_q <= cmd_data[PART_IDX_W-1:0];
                  end
                  // oversized counts saturate so the check still rejects them
                  CMD_PART_NUM: begin
                    shd_pn_q <= (|cmd_data[XMEM_DW-1:PART_IDX_W+1]) ? '1 : cmd_data[PART_IDX_W:0];
                  end
                  CMD_RANGE_START: begin
                    shd_rs_q[cur_part_q] <= cmd_data[XMEM_AW-1:0];
                    if (cur_part_q != PART_IDX_W'(MAX_PARTITION)) cur_part_q <= cur_part_q + PART_IDX_W'(1);
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        ST_CHECK: begin
          if (!chk_ok_d) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (chk_last_d) begin
            state_q <= ST_COMMIT;
          end else begin
            chk_idx_q <= chk_nxt_d;
          end
        end
        ST_COMMIT: begin
          act_rs_q   <= shd_rs_q;
          act_pn_q   <= shd_pn_q;
          cur_part_q <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_busy     = !cmd_ready;
  assign cfg_done     = (state_q == ST_COMMIT);
  assign cfg_err      = err_q;
  assign fwd_valid    = fwd_valid_q;
  assign fwd_id       = fwd_id_q;
  assign fwd_data     = fwd_data_q;
  assign sbank        = sbank_q;
  assign rport        = rport_q;
  assign aport        = aport_q;
  assign axi_mem_base = axi_base_q;
  assign part_num     = act_pn_q;

  xcache_part_lookup u_lookup (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .tbl_i       (act_rs_q),
    .part_num_i  (act_pn_q),
    .valid_i     (lkp_valid),
    .addr_i      (lkp_addr),
    .rsp_valid_o (lkp_rsp_valid),
    .hit_o       (lkp_hit),
    .part_o      (lkp_part),
    .end_o       (lkp_end)
  );

`ifdef XCACHE_CFG_READBACK_EN
  logic                 rd_rsp_valid_q;
  logic [XMEM_AW-1:0]   rd_data_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_rsp_valid_q <= 1'b0;
      rd_data_q      <= '0;
    end else begin
      rd_rsp_valid_q <= rd_valid;
      if (rd_valid) rd_data_q <= (rd_idx > PART_IDX_W'(MAX_PARTITION)) ? '0 : act_rs_q[rd_idx];
    end
  end

  assign rd_rsp_valid = rd_rsp_valid_q;
  assign rd_data      = rd_data_q;
`endif

endmodule

// File: tb/tb_xcache_cfg_decoder.sv
// Directed self-checking bench for xcache_cfg_decoder (default build, readback port absent).
module tb_xcache_cfg_decoder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_commit;
  logic [5:0]  cmd_id;
  logic [31:0] cmd_data;
  logic        fwd_valid;
  logic [5:0]  fwd_id;
  logic [31:0] fwd_data;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  sbank, rport, aport;
  logic [31:0] axi_mem_base;
  logic [3:0]  part_num;
  logic        lkp_valid;
  logic [28:0] lkp_addr;
  logic        lkp_rsp_valid, lkp_hit;
  logic [2:0]  lkp_part;
  logic [28:0] lkp_end;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  bit saw;

  always #5 clk = ~clk;

  xcache_cfg_decoder dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_commit(cmd_commit),
    .cmd_id(cmd_id), .cmd_data(cmd_data),
    .fwd_valid(fwd_valid), .fwd_id(fwd_id), .fwd_data(fwd_data),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .sbank(sbank), .rport(rport), .aport(aport), .axi_mem_base(axi_mem_base),
    .part_num(part_num),
    .lkp_valid(lkp_valid), .lkp_addr(lkp_addr), .lkp_rsp_valid(lkp_rsp_valid),
    .lkp_hit(lkp_hit), .lkp_part(lkp_part), .lkp_end(lkp_end)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic com, input logic [5:0] id, input logic [31:0] d);
    int w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("beat_ready", cmd_ready, 1'b1);
    cmd_valid  = 1'b1;
    cmd_commit = com;
    cmd_id     = id;
    cmd_data   = d;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_commit = 1'b0;
  endtask

  task automatic look(input string tag, input logic [28:0] a,
                      input logic eh, input logic [2:0] ep, input logic [28:0] ee);
    @(negedge clk);
    lkp_valid = 1'b1;
    lkp_addr  = a;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk({tag, "_vld"},  lkp_rsp_valid, 1'b1);
    chk({tag, "_hit"},  lkp_hit, eh);
    chk({tag, "_part"}, lkp_part, ep);
    chk({tag, "_end"},  lkp_end, ee);
  endtask

  // Called just after the commit beat is accepted; counts cycles until ready returns.
  task automatic wait_idle(output int c, output bit sd);
    c  = 0;
    sd = 1'b0;
    while (!cmd_ready && c < 50) begin
      @(posedge clk); #1;
      c++;
      if (cfg_done) sd = 1'b1;
    end
    chk("idle_timeout", (c >= 50), 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_commit = 1'b0; cmd_id = '0; cmd_data = '0;
    lkp_valid = 1'b0; lkp_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;

    // reset state
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_fwd", fwd_valid, 1'b0);
    chk("rst_sbank", sbank, 8'h00);
    chk("rst_axi", axi_mem_base, 32'h0);
    chk("rst_pnum", part_num, 4'd1);
    chk("rst_lkpv", lkp_rsp_valid, 1'b0);
    look("rst_lkp0", 29'h0, 1'b0, 3'd0, 29'h0);

    // first table: 0x000 / 0x100 / 0x300, two partitions
    beat(0, 6'd4, 32'd2);
    beat(0, 6'd3, 32'd0);
    beat(0, 6'd5, 32'h000);
    beat(0, 6'd5, 32'h100);
    beat(0, 6'd5, 32'h300);
    beat(1, 6'd0, 32'd0);
    chk("c1_busy0", cfg_busy, 1'b1);
    chk("c1_done0", cfg_done, 1'b0);
    @(posedge clk); #1;
    chk("c1_busy1", cfg_busy, 1'b1);
    chk("c1_done1", cfg_done, 1'b0);
    @(posedge clk); #1;
    chk("c1_done2", cfg_done, 1'b1);
    @(posedge clk); #1;
    chk("c1_busy3", cfg_busy, 1'b0);
    chk("c1_done3", cfg_done, 1'b0);
    chk("c1_pnum", part_num, 4'd2);
    chk("c1_err", cfg_err, 1'b0);
    look("l150", 29'h150, 1'b1, 3'd1, 29'h2FF);
    look("l000", 29'h000, 1'b1, 3'd0, 29'h0FF);
    look("l2ff", 29'h2FF, 1'b1, 3'd1, 29'h2FF);

    // rs[0] -> 0x080; a lookup sampled in the COMMIT cycle sees the old table
    beat(0, 6'd3, 32'd0);
    beat(0, 6'd5, 32'h080);
    beat(1, 6'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("c2_done", cfg_done, 1'b1);
    lkp_valid = 1'b1;
    lkp_addr  = 29'h050;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk("c2_lkpc_hit", lkp_hit, 1'b1);
    chk("c2_lkpc_end", lkp_end, 29'h0FF);
    chk("c2_busy", cfg_busy, 1'b0);
    look("l300", 29'h300, 1'b0, 3'd0, 29'h0);
    look("l050", 29'h050, 1'b0, 3'd0, 29'h0);
    look("l080", 29'h080, 1'b1, 3'd0, 29'h0FF);

    // non-increasing table is rejected on the first compare
    beat(0, 6'd3, 32'd0);
    beat(0, 6'd5, 32'h100);
    beat(0, 6'd5, 32'h100);
    beat(0, 6'd5, 32'h200);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("bad_cyc", cyc, 1);
    chk("bad_done", saw, 1'b0);
    chk("bad_err", cfg_err, 1'b1);
    chk("bad_pnum", part_num, 4'd2);
    look("bad_l150", 29'h150, 1'b1, 3'd1, 29'h2FF);

    // restore a good shadow; commit clears error
    beat(0, 6'd3, 32'd0);
    beat(0, 6'd5, 32'h080);
    beat(0, 6'd5, 32'h100);
    beat(0, 6'd5, 32'h300);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("rst_cyc", cyc, 3);
    chk("rst_done_seen", saw, 1'b1);
    chk("rst_err_clr", cfg_err, 1'b0);

    // unknown code 0x2A
    beat(0, 6'h2A, 32'h1234);
    chk("x2a_err", cfg_err, 1'b1);
    chk("x2a_ready", cmd_ready, 1'b1);
    chk("x2a_fwd", fwd_valid, 1'b0);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("x2a_clr_done", saw, 1'b1);
    chk("x2a_clr_err", cfg_err, 1'b0);

    // SET_PART limits and RANGE_START saturation at the last entry
    beat(0, 6'd3, 32'd4);
    chk("sp4_err", cfg_err, 1'b0);
    beat(0, 6'd3, 32'd5);
    chk("sp5_err", cfg_err, 1'b1);
    beat(0, 6'd3, 32'd3);
    beat(0, 6'd5, 32'h400);
    beat(0, 6'd5, 32'h500);
    beat(0, 6'd5, 32'h600);
    beat(0, 6'd4, 32'd4);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("p4_cyc", cyc, 5);
    chk("p4_done", saw, 1'b1);
    chk("p4_err", cfg_err, 1'b0);
    chk("p4_pnum", part_num, 4'd4);
    look("l5ff", 29'h5FF, 1'b1, 3'd3, 29'h5FF);
    look("l600", 29'h600, 1'b0, 3'd0, 29'h0);
    look("l3ff", 29'h3FF, 1'b1, 3'd2, 29'h3FF);

    // part_num bounds
    beat(0, 6'd4, 32'd0);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("pn0_cyc", cyc, 1);
    chk("pn0_done", saw, 1'b0);
    chk("pn0_err", cfg_err, 1'b1);
    beat(0, 6'd4, 32'd5);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("pn5_cyc", cyc, 1);
    chk("pn5_done", saw, 1'b0);
    chk("pn5_err", cfg_err, 1'b1);
    chk("pn5_pnum", part_num, 4'd4);

    // forwarding, including range edges 6 and 39
    beat(0, 6'd17, 32'h55);
    chk("f17_vld", fwd_valid, 1'b1);
    chk("f17_id", fwd_id, 6'd17);
    chk("f17_data", fwd_data, 32'h55);
    @(posedge clk); #1;
    chk("f17_pulse", fwd_valid, 1'b0);
    chk("f17_pnum", part_num, 4'd4);
    look("f17_l5ff", 29'h5FF, 1'b1, 3'd3, 29'h5FF);
    beat(0, 6'd39, 32'hABCD);
    chk("f39_vld", fwd_valid, 1'b1);
    chk("f39_id", fwd_id, 6'd39);
    chk("f39_data", fwd_data, 32'hABCD);
    beat(0, 6'd6, 32'h7);
    chk("f6_id", fwd_id, 6'd6);

    // unshadowed direct registers
    beat(0, 6'd0, 32'h1A5);
    chk("sbank", sbank, 8'hA5);
    beat(0, 6'd1, 32'h3C);
    chk("rport", rport, 8'h3C);
    beat(0, 6'd2, 32'h7E);
    chk("aport", aport, 8'h7E);
    beat(0, 6'd40, 32'hDEADBEEF);
    chk("axi", axi_mem_base, 32'hDEADBEEF);
    chk("axi_fwd", fwd_valid, 1'b0);

    // reset while CHECK is running
    beat(0, 6'd4, 32'd4);
    beat(1, 6'd0, 32'd0);
    chk("mr_busy", cfg_busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk("mr_ready", cmd_ready, 1'b1);
    chk("mr_busy0", cfg_busy, 1'b0);
    chk("mr_done", cfg_done, 1'b0);
    chk("mr_err", cfg_err, 1'b0);
    chk("mr_sbank", sbank, 8'h00);
    chk("mr_rport", rport, 8'h00);
    chk("mr_aport", aport, 8'h00);
    chk("mr_axi", axi_mem_base, 32'h0);
    chk("mr_pnum", part_num, 4'd1);
    chk("mr_lkpv", lkp_rsp_valid, 1'b0);
    chk("mr_hit", lkp_hit, 1'b0);
    @(negedge clk) rstn = 1'b1;
    look("mr_l0", 29'h0, 1'b0, 3'd0, 29'h0);
    look("mr_l150", 29'h150, 1'b0, 3'd0, 29'h0);
    beat(1, 6'd0, 32'd0);
    wait_idle(cyc, saw);
    chk("mr_c_cyc", cyc, 1);
    chk("mr_c_done", saw, 1'b0);
    chk("mr_c_err", cfg_err, 1'b1);
    chk("mr_c_pnum", part_num, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
